hist2d_accum: RTL and testbench

Parametrised 2D IQ histogram engine: accumulates binned (i,q) samples into an internal block RAM at one sample per clock and streams the populated bin region out through a valid/ready handshake. It is the successor to the hist2d_store_bin + hist2d_bin_out_stream + hist2d_bram trio:

- memory, store and stream are merged, so no external port muxing is needed;
- same-bin hits are accepted back to back;
- counters saturate;
- clear-on-read and hardware memory clear are built in.

It sits after the IQ binning stage and feeds the host readout path.

---
 rtl/hist2d_accum.sv | 252 +++++++++++++++++++++++++
 tb/tb_hist2d_accum.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist2d_accum.sv
// 2D IQ histogram: one (i,q) sample per clock is counted into block RAM, visible two edges after acceptance.
// Streams the active bin region 4 cycles after start at 1 bin/clk; a 2-entry skid holds data while data_ready is low.
module hist2d_accum #(
  parameter int I_W           = 8,
  parameter int Q_W           = 8,
  parameter int CNT_W         = 16,
  parameter bit CLEAR_ON_READ = 1'b0
) (
  input  logic             clk100,
  input  logic             reset_n,
  input  logic [I_W:0]     i_bin_num,
  input  logic [Q_W:0]     q_bin_num,
  input  logic             data_in,
  input  logic [I_W-1:0]   i_bin_coord,
  input  logic [Q_W-1:0]   q_bin_coord,
  input  logic             clear,
  input  logic             start_data_out,
  input  logic             data_ready,
  output logic             data_out,
  output logic [CNT_W-1:0] bin_val,
  output logic [I_W-1:0]   i_bin_out,
  output logic [Q_W-1:0]   q_bin_out,
  output logic             last,
  output logic             busy,
  output logic [31:0]      total_count,
  output logic [15:0]      dropped_count
);
  localparam int AW    = I_W + Q_W;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {ST_CLEAR, ST_ACCUM, ST_DRAIN, ST_STREAM} state_t;

  typedef struct packed {
    logic             last;
    logic [Q_W-1:0]   q;
    logic [I_W-1:0]   i;
    logic [CNT_W-1:0] val;
  } bin_t;

  state_t state, state_nxt;
  logic   in_clear, in_accum, in_stream, go_stream;
  logic   xfer, xfer_last;

  logic [AW-1:0] clr_addr;
  logic          drain_cnt;
  logic [I_W:0]  i_lim, i_max;
  logic [Q_W:0]  q_lim, q_max;

  // accumulate pipeline
  logic             in_range, acc_hit;
  logic             s0_vld, s1_vld, fwd_vld;
  logic [AW-1:0]    s0_addr, s1_addr, fwd_addr;
  logic [CNT_W-1:0] fwd_dat, s1_op, s1_sum;

  // RAM ports
  logic [CNT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_addr, wr_addr;
  logic [CNT_W-1:0] rd_dat, wr_dat;
  logic             wr_en;

  // stream engine
  logic [I_W-1:0] st_i, rd_i;
  logic [Q_W-1:0] st_q, rd_q;
  logic           st_done, st_rd, st_last_bin;
  logic           rd_vld, rd_last, sk_vld;
  logic [1:0]     occ;
  bin_t           rd_bin, sk_bin, out_bin;

  // ---------------- FSM ----------------
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) state <= ST_CLEAR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR:  if (&clr_addr) state_nxt = ST_ACCUM;
      ST_ACCUM:  if (clear) state_nxt = ST_CLEAR;
                 else if (start_data_out) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt) state_nxt = ST_STREAM;
      ST_STREAM: if (xfer_last) state_nxt = ST_ACCUM;
      default:   state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    in_clear  = (state == ST_CLEAR);
    in_accum  = (state == ST_ACCUM);
    in_stream = (state == ST_STREAM);
    busy      = !in_accum;
    go_stream = in_accum && !clear && start_data_out;
  end

  assign xfer      = data_out && data_ready;
  assign xfer_last = xfer && out_bin.last;

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      clr_addr  <= '0;
      drain_cnt <= 1'b0;
      i_lim     <= {1'b1, {I_W{1'b0}}};
      q_lim     <= {1'b1, {Q_W{1'b0}}};
    end else begin
      clr_addr  <= in_clear ? clr_addr + AW'(1) : '0;
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      if (go_stream) begin
        i_lim <= i_bin_num;
        q_lim <= q_bin_num;
      end
    end
  end

  assign i_max = i_lim - {{I_W{1'b0}}, 1'b1};
  assign q_max = q_lim - {{Q_W{1'b0}}, 1'b1};

  // ---------------- accumulate ----------------
  assign in_range = ({1'b0, i_bin_coord} < i_lim) && ({1'b0, q_bin_coord} < q_lim);
  assign acc_hit  = data_in && in_accum && !clear && in_range;

  // The read issued for S0 misses the write landing on the same edge; fwd_* holds that write.
  assign s1_op  = (fwd_vld && fwd_addr == s1_addr) ? fwd_dat : rd_dat;
  assign s1_sum = (&s1_op) ? s1_op : s1_op + CNT_W'(1);

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      s0_vld   <= 1'b0;
      s0_addr  <= '0;
      s1_vld   <= 1'b0;
      s1_addr  <= '0;
      fwd_vld  <= 1'b0;
      fwd_addr <= '0;
      fwd_dat  <= '0;
    end else begin
      s0_vld   <= acc_hit;
      s0_addr  <= {q_bin_coord, i_bin_coord};
      s1_vld   <= s0_vld && !in_clear;
      s1_addr  <= s0_addr;
      fwd_vld  <= s1_vld && !in_clear;
      fwd_addr <= s1_addr;
      fwd_dat  <= s1_sum;
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      total_count   <= '0;
      dropped_count <= '0;
    end else if (in_clear) begin
      total_count   <= '0;
      dropped_count <= '0;
    end else begin
      if (acc_hit && !(&total_count))
        total_count <= total_count + 32'd1;
      if (data_in && !acc_hit && !(&dropped_count))
        dropped_count <= dropped_count + 16'd1;
    end
  end

  // ---------------- RAM ----------------
  // Clearing owns the write port; pending S1 writes are dropped since their bins get zeroed anyway.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s1_addr;
    wr_dat  = s1_sum;
    if (in_clear) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_dat  = '0;
    end else if (s1_vld) begin
      wr_en   = 1'b1;
    end else if (CLEAR_ON_READ && xfer) begin
      wr_en   = 1'b1;
      wr_addr = {out_bin.q, out_bin.i};
      wr_dat  = '0;
    end
  end

  assign rd_addr = st_rd ? {st_q, st_i} : s0_addr;

  always_ff @(posedge clk100) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    rd_dat <= mem[rd_addr];
  end

  // ---------------- stream ----------------
  // Reads are issued only while output reg + skid + in-flight read leave room after this cycle's transfer.
  assign occ         = {1'b0, data_out} + {1'b0, sk_vld} + {1'b0, rd_vld} - {1'b0, xfer};
  assign st_last_bin = ({1'b0, st_i} == i_max) && ({1'b0, st_q} == q_max);
  assign st_rd       = in_stream && !st_done && (occ < 2'd2);
  assign rd_bin      = {rd_last, rd_q, rd_i, rd_dat};

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      st_i    <= '0;
      st_q    <= '0;
      st_done <= 1'b0;
      rd_vld  <= 1'b0;
      rd_i    <= '0;
      rd_q    <= '0;
      rd_last <= 1'b0;
    end else begin
      if (go_stream) begin
        st_i    <= '0;
        st_q    <= '0;
        st_done <= 1'b0;
      end else if (st_rd) begin
        if (st_last_bin) st_done <= 1'b1;
        if ({1'b0, st_i} == i_max) begin
          st_i <= '0;
          st_q <= st_q + Q_W'(1);
        end else begin
          st_i <= st_i + I_W'(1);
        end
      end
      rd_vld  <= st_rd;
      rd_i    <= st_i;
      rd_q    <= st_q;
      rd_last <= st_last_bin;
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= 1'b0;
      out_bin  <= '0;
      sk_vld   <= 1'b0;
      sk_bin   <= '0;
    end else if (!data_out || xfer) begin
      if (sk_vld) begin
        data_out <= 1'b1;
        out_bin  <= sk_bin;
        sk_vld   <= rd_vld;
        if (rd_vld) sk_bin <= rd_bin;
      end else if (rd_vld) begin
        data_out <= 1'b1;
        out_bin  <= rd_bin;
      end else begin
        data_out <= 1'b0;
      end
    end else if (rd_vld) begin
      sk_vld <= 1'b1;
      sk_bin <= rd_bin;
    end
  end

  assign bin_val   = out_bin.val;
  assign i_bin_out = out_bin.i;
  assign q_bin_out = out_bin.q;
  assign last      = out_bin.last;

endmodule

// File: tb/tb_hist2d_accum.sv
// Drives two hist2d_accum instances in lockstep (16-bit plain, 4-bit clear-on-read) and
// compares every presented bin and counter against an array model of the histogram.
module tb_hist2d_accum;
  localparam int IW = 4;
  localparam int QW = 4;

  logic          clk100 = 1'b0;
  logic          reset_n;
  logic [IW:0]   i_bin_num, q_bin_num;
  logic          data_in, clear, start_data_out, data_ready;
  logic [IW-1:0] i_bin_coord;
  logic [QW-1:0] q_bin_coord;

  logic          data_out0, data_out1, last0, last1, busy0, busy1;
  logic [15:0]   bin_val0;
  logic [3:0]    bin_val1;
  logic [IW-1:0] i_out0, i_out1;
  logic [QW-1:0] q_out0, q_out1;
  logic [31:0]   total0, total1;
  logic [15:0]   drop0, drop1;

  int m_cnt0 [256];
  int m_cnt1 [256];
  int m_total, m_drop, m_ilim, m_qlim;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk100 = ~clk100;

  hist2d_accum #(.I_W(IW), .Q_W(QW), .CNT_W(16), .CLEAR_ON_READ(1'b0)) u_plain (
    .clk100(clk100), .reset_n(reset_n), .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
    .data_in(data_in), .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .clear(clear), .start_data_out(start_data_out), .data_ready(data_ready),
    .data_out(data_out0), .bin_val(bin_val0), .i_bin_out(i_out0), .q_bin_out(q_out0),
    .last(last0), .busy(busy0), .total_count(total0), .dropped_count(drop0));

  hist2d_accum #(.I_W(IW), .Q_W(QW), .CNT_W(4), .CLEAR_ON_READ(1'b1)) u_cor (
    .clk100(clk100), .reset_n(reset_n), .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
    .data_in(data_in), .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .clear(clear), .start_data_out(start_data_out), .data_ready(data_ready),
    .data_out(data_out1), .bin_val(bin_val1), .i_bin_out(i_out1), .q_bin_out(q_out1),
    .last(last1), .busy(busy1), .total_count(total1), .dropped_count(drop1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic model_clear();
    for (int a = 0; a < 256; a++) begin
      m_cnt0[a] = 0;
      m_cnt1[a] = 0;
    end
    m_total = 0;
    m_drop  = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_ilim = 16;
    m_qlim = 16;
  endtask

  // One sample while the block is accumulating; the model decides accept vs reject.
  task automatic drive_sample(input int i, input int q);
    int a;
    data_in     = 1'b1;
    i_bin_coord = IW'(i);
    q_bin_coord = QW'(q);
    if (i < m_ilim && q < m_qlim) begin
      a = q * 16 + i;
      if (m_cnt0[a] < 65535) m_cnt0[a]++;
      if (m_cnt1[a] < 15)    m_cnt1[a]++;
      m_total++;
    end else begin
      m_drop++;
    end
    step();
    data_in = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_total0"}, total0, m_total);
    chk({tag, "_total1"}, total1, m_total);
    chk({tag, "_drop0"},  drop0,  m_drop);
    chk({tag, "_drop1"},  drop1,  m_drop);
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while ((busy0 || busy1) && n < 1000) begin
      step();
      n++;
    end
    chk(tag, n, 256);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_stream(input int mode, input bit inject, input int abort_at);
    int  idx, nb, cyc, lat, a, ei, eq;
    bit  rdy;
    start_data_out = 1'b1;
    step();
    start_data_out = 1'b0;
    m_ilim = int'(i_bin_num);
    m_qlim = int'(q_bin_num);
    nb  = m_ilim * m_qlim;
    lat = 0;
    while (!data_out0 && lat < 20) begin
      step();
      lat++;
    end
    chk("stream_latency", lat, 4);
    idx = 0;
    cyc = 0;
    while (idx < nb && cyc < 4000) begin
      if (idx == abort_at) begin
        reset_n    = 1'b0;
        data_ready = 1'b0;
        #1;
        chk("abort_dout",  {data_out0, data_out1}, 2'b00);
        chk("abort_busy",  {busy0, busy1}, 2'b11);
        chk("abort_total", total0, 0);
        @(posedge clk100);
        #1;
        reset_n = 1'b1;
        model_reset();
        wait_clear("reset_clear_len");
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      data_ready = rdy;
      if (data_out0 || data_out1) begin
        ei = idx % m_ilim;
        eq = idx / m_ilim;
        a  = eq * 16 + ei;
        chk("dout_pair", {data_out0, data_out1}, 2'b11);
        chk("i_out0",  i_out0, ei);
        chk("q_out0",  q_out0, eq);
        chk("i_out1",  i_out1, ei);
        chk("q_out1",  q_out1, eq);
        chk("bin_val0", bin_val0, m_cnt0[a]);
        chk("bin_val1", bin_val1, m_cnt1[a]);
        chk("last", {last0, last1}, (idx == nb - 1) ? 2'b11 : 2'b00);
        if (rdy) begin
          m_cnt1[a] = 0;
          idx++;
        end
      end
      data_in     = inject && (cyc == 3);
      i_bin_coord = '0;
      q_bin_coord = '0;
      if (data_in) m_drop++;
      step();
      cyc++;
    end
    data_in    = 1'b0;
    data_ready = 1'b0;
    chk("stream_len", idx, nb);
    chk("end_dout", {data_out0, data_out1}, 2'b00);
    chk("end_busy", {busy0, busy1}, 2'b00);
  endtask

  initial begin
    reset_n        = 1'b0;
    data_in        = 1'b0;
    clear          = 1'b0;
    start_data_out = 1'b0;
    data_ready     = 1'b0;
    i_bin_coord    = '0;
    q_bin_coord    = '0;
    i_bin_num      = 5'd16;
    q_bin_num      = 5'd16;
    model_reset();
    step();
    step();
    chk("rst_dout",  {data_out0, data_out1}, 2'b00);
    chk("rst_busy",  {busy0, busy1}, 2'b11);
    chk("rst_val",   {bin_val0, bin_val1}, 0);
    chk("rst_coord", {i_out0, q_out0, i_out1, q_out1}, 0);
    chk("rst_last",  {last0, last1}, 2'b00);
    check_counters("rst");
    reset_n = 1'b1;
    wait_clear("init_clear_len");

    // diagonal, 10x10 readout
    i_bin_num = 5'd10;
    q_bin_num = 5'd10;
    for (int k = 1; k <= 5; k++) begin
      drive_sample(k, k);
      repeat (4) step();
    end
    check_counters("basic");
    run_stream(0, 1'b0, -1);

    // same-bin back to back
    repeat (6) drive_sample(3, 2);
    drive_sample(3, 2);
    drive_sample(4, 2);
    drive_sample(3, 2);
    repeat (3) step();
    check_counters("hazard");
    run_stream(1, 1'b0, -1);

    // saturation of the 4-bit instance
    repeat (20) drive_sample(0, 0);
    repeat (3) step();
    check_counters("sat");
    run_stream(2, 1'b0, -1);

    // out-of-range plus a sample during STREAM, then a second readout
    drive_sample(12, 0);
    drive_sample(2, 9);
    repeat (3) step();
    run_stream(0, 1'b1, -1);
    check_counters("reject");
    run_stream(1, 1'b0, -1);

    // clear together with start: clear wins and the limits stay at 10x10
    i_bin_num      = 5'd3;
    clear          = 1'b1;
    start_data_out = 1'b1;
    step();
    clear          = 1'b0;
    start_data_out = 1'b0;
    model_clear();
    wait_clear("clear_len");
    check_counters("cleared");
    drive_sample(5, 0);
    repeat (3) step();
    check_counters("post_clear");
    i_bin_num = 5'd10;
    run_stream(0, 1'b0, -1);

    // random traffic with random bin regions
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(0, 2) != 0)
          drive_sample(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        else
          step();
      end
      repeat (3) step();
      check_counters("rand");
      i_bin_num = 5'($urandom_range(1, 16));
      q_bin_num = 5'($urandom_range(1, 16));
      run_stream(2, 1'b0, -1);
    end

    // reset in the middle of a stream, then everything reads back zero
    i_bin_num = 5'd10;
    q_bin_num = 5'd10;
    for (int k = 0; k < 12; k++) drive_sample(k % 10, (k * 3) % 10);
    repeat (3) step();
    run_stream(0, 1'b0, 37);
    check_counters("post_reset");
    run_stream(0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
